// File: rtl/video_timing_pkg.sv
// Shared display-timing constants and types for the sync generator,
// pattern generator and their benches. Defaults describe 640x480@60.
package video_timing_pkg;

  localparam int CW = 10;
  localparam logic SYNC_POL = 1'b0;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_WIDTH  = 96;
  localparam int H_BACK   = 48;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_WIDTH  = 2;
  localparam int V_BACK   = 33;

  typedef logic [CW-1:0] tcnt_t;

endpackage

// File: rtl/syncgen_if.sv
// Timing bus between the sync generator (master) and its consumers (slave).
// locked comes from the pixel-clock generator; everything else is produced
// by the sync generator.
interface syncgen_if;
  import video_timing_pkg::*;

  logic  locked;
  tcnt_t hcnt;
  tcnt_t vcnt;
  logic  hsync;
  logic  vsync;
  logic  de;
  logic  frame_start;

  modport master (
    input  locked,
    output hcnt, vcnt, hsync, vsync, de, frame_start
  );

  modport slave (
    input locked, hcnt, vcnt, hsync, vsync, de, frame_start
  );

endinterface

// File: rtl/syncgen.sv
// Display timing generator: pixel/line counters plus one registered decode
// stage, so hsync/vsync/de/frame_start trail the counters by one pixel clock.
// A consumer that registers pixel data from hcnt/vcnt once lines up with them.
// HPERIOD-1 and VPERIOD-1 must fit in the package counter width.
module syncgen #(
  parameter int   H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int   H_FRONT  = video_timing_pkg::H_FRONT,
  parameter int   H_WIDTH  = video_timing_pkg::H_WIDTH,
  parameter int   H_BACK   = video_timing_pkg::H_BACK,
  parameter int   V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int   V_FRONT  = video_timing_pkg::V_FRONT,
  parameter int   V_WIDTH  = video_timing_pkg::V_WIDTH,
  parameter int   V_BACK   = video_timing_pkg::V_BACK,
  parameter logic SYNC_POL = video_timing_pkg::SYNC_POL
) (
  input logic       pck,
  input logic       rst_n,
  syncgen_if.master bus
);
  import video_timing_pkg::*;

  localparam int HPERIOD = H_ACTIVE + H_FRONT + H_WIDTH + H_BACK;
  localparam int VPERIOD = V_ACTIVE + V_FRONT + V_WIDTH + V_BACK;

  // All decode bounds are pre-sized to the counter width so every compare
  // is a plain unsigned CW-bit compare with no intermediate arithmetic.
  localparam tcnt_t H_LAST   = tcnt_t'(HPERIOD - 1);
  localparam tcnt_t V_LAST   = tcnt_t'(VPERIOD - 1);
  localparam tcnt_t H_VIS    = tcnt_t'(H_ACTIVE);
  localparam tcnt_t V_VIS    = tcnt_t'(V_ACTIVE);
  localparam tcnt_t HS_START = tcnt_t'(H_ACTIVE + H_FRONT);
  localparam tcnt_t HS_END   = tcnt_t'(H_ACTIVE + H_FRONT + H_WIDTH);
  localparam tcnt_t VS_START = tcnt_t'(V_ACTIVE + V_FRONT);
  localparam tcnt_t VS_END   = tcnt_t'(V_ACTIVE + V_FRONT + V_WIDTH);
  localparam logic  SYNC_IDLE = ~SYNC_POL;

  tcnt_t hcnt;
  tcnt_t vcnt;
  logic  hsync;
  logic  vsync;
  logic  de;
  logic  frame_start;
  logic  line_end;

  assign line_end = (hcnt == H_LAST);

  // Pixel and line counters; losing lock parks the raster at the origin.
  always_ff @(posedge pck or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!bus.locked) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + tcnt_t'(1);
    end else begin
      hcnt <= hcnt + tcnt_t'(1);
    end
  end

  // Registered decode of the current counter position.
  always_ff @(posedge pck or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else if (!bus.locked) begin
      de          <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      de          <= (hcnt < H_VIS) && (vcnt < V_VIS);
      hsync       <= ((hcnt >= HS_START) && (hcnt < HS_END)) ? SYNC_POL : SYNC_IDLE;
      vsync       <= ((vcnt >= VS_START) && (vcnt < VS_END)) ? SYNC_POL : SYNC_IDLE;
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

  assign bus.hcnt        = hcnt;
  assign bus.vcnt        = vcnt;
  assign bus.hsync       = hsync;
  assign bus.vsync       = vsync;
  assign bus.de          = de;
  assign bus.frame_start = frame_start;

endmodule
